// File: rtl/cpu_clock_pkg.sv
// Shared types and the half-period helper for the PHI2 generator.
package cpu_clock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PHI1 = 2'd1,
        PHI2 = 2'd2
    } cpu_clock_state_t;

    typedef enum logic [1:0] {
        SPEED_1X = 2'd0,
        SPEED_2X = 2'd1,
        SPEED_4X = 2'd2,
        SPEED_8X = 2'd3
    } cpu_speed_t;

    // Ticks spent in each PHI2 phase at the given speed.
    function automatic int unsigned half_ticks(input int unsigned cycle_ticks, input cpu_speed_t speed);
        return (cycle_ticks >> speed) / 2;
    endfunction

endpackage

// File: rtl/cpu_clock_gen.sv
// PHI2 generator for the 6502 wrapper with speed select, clean run/halt and edge strobes.
// Optional PHI2-high stretching via `define CPU_CLOCK_STRETCH_EN (adds stretch_i).
module cpu_clock_gen
    import cpu_clock_pkg::*;
#(
    parameter int unsigned CYCLE_TICKS = 64,
    parameter int unsigned SETUP_TICKS = 2
) (
    input  logic       sys_clock_i,
    input  logic       reset_n_i,
    input  logic       run_i,
    input  logic [1:0] speed_i,
`ifdef CPU_CLOCK_STRETCH_EN
    input  logic       stretch_i,
`endif
    output logic       cpu_clock_o,
    output logic       phi2_rise_o,
    output logic       phi2_fall_o,
    output logic       data_setup_o,
    output logic       halted_o
);

    localparam int CW = $clog2(CYCLE_TICKS / 2);

    if (CYCLE_TICKS < 16 || (CYCLE_TICKS & (CYCLE_TICKS - 1)) != 0 ||
        SETUP_TICKS < 1 || SETUP_TICKS >= CYCLE_TICKS / 16) begin : g_bad_params
        $error("cpu_clock_gen: illegal CYCLE_TICKS/SETUP_TICKS combination");
    end

    cpu_clock_state_t state;
    cpu_speed_t       spd;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    load_new;
    logic [CW-1:0]    load_cur;
    logic             stretch;

`ifdef CPU_CLOCK_STRETCH_EN
    assign stretch = stretch_i;
`else
    assign stretch = 1'b0;
`endif

    // load_new uses the live speed for a PHI1 entry; load_cur keeps PHI2 at the latched speed.
    assign load_new = CW'(half_ticks(CYCLE_TICKS, cpu_speed_t'(speed_i)) - 1);
    assign load_cur = CW'(half_ticks(CYCLE_TICKS, spd) - 1);

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            spd          <= SPEED_1X;
            cnt          <= '0;
            cpu_clock_o  <= 1'b0;
            phi2_rise_o  <= 1'b0;
            phi2_fall_o  <= 1'b0;
            data_setup_o <= 1'b0;
            halted_o     <= 1'b1;
        end else begin
            phi2_rise_o  <= 1'b0;
            phi2_fall_o  <= 1'b0;
            data_setup_o <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_clock_o <= 1'b0;
                    halted_o    <= 1'b1;
                    if (run_i) begin
                        spd      <= cpu_speed_t'(speed_i);
                        cnt      <= load_new;
                        state    <= PHI1;
                        halted_o <= 1'b0;
                    end
                end
                PHI1: begin
                    if (cnt == '0) begin
                        state       <= PHI2;
                        cpu_clock_o <= 1'b1;
                        phi2_rise_o <= 1'b1;
                        cnt         <= load_cur;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PHI2: begin
                    // Counter parks at 0 during a stretch, so the setup strobe cannot repeat.
                    if (cnt == CW'(SETUP_TICKS))
                        data_setup_o <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!stretch) begin
                        cpu_clock_o <= 1'b0;
                        phi2_fall_o <= 1'b1;
                        if (run_i) begin
                            spd   <= cpu_speed_t'(speed_i);
                            cnt   <= load_new;
                            state <= PHI1;
                        end else begin
                            state    <= IDLE;
                            halted_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Directed bench for cpu_clock_gen at CYCLE_TICKS=64, SETUP_TICKS=2; samples on the falling clock edge.
module tb_cpu_clock_gen;

    logic       sys_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       run       = 1'b0;
    logic [1:0] speed     = 2'd0;
    logic       stretch   = 1'b0;
    logic       cpu_clock_o, phi2_rise_o, phi2_fall_o, data_setup_o, halted_o;

    int checks = 0;
    int errors = 0;

    always #5 sys_clock = ~sys_clock;

    cpu_clock_gen #(.CYCLE_TICKS(64), .SETUP_TICKS(2)) dut (
        .sys_clock_i (sys_clock),
        .reset_n_i   (reset_n),
        .run_i       (run),
        .speed_i     (speed),
`ifdef CPU_CLOCK_STRETCH_EN
        .stretch_i   (stretch),
`endif
        .cpu_clock_o (cpu_clock_o),
        .phi2_rise_o (phi2_rise_o),
        .phi2_fall_o (phi2_fall_o),
        .data_setup_o(data_setup_o),
        .halted_o    (halted_o)
    );

    // Starting at a rise sample: count high samples up to the fall sample.
    task automatic measure_high(output int hi, output int gap, output int nsetup,
                                output int nrise, output bit fell_ok, output bit to);
        int setup_k;
        hi = 1; gap = -1; nsetup = 0; nrise = 0; fell_ok = 0; to = 1; setup_k = -100;
        for (int k = 1; k <= 200; k++) begin
            @(negedge sys_clock);
            if (phi2_fall_o) begin
                fell_ok = (cpu_clock_o == 1'b0);
                gap = k - setup_k;
                to = 0;
                break;
            end
            if (cpu_clock_o) hi++;
            if (phi2_rise_o) nrise++;
            if (data_setup_o) begin nsetup++; setup_k = k; end
        end
    endtask

    // Starting at a fall sample: count low samples up to the next rise sample.
    task automatic measure_low(output int lo, output bit fall_w1, output bit rise_ok, output bit to);
        lo = 1; fall_w1 = 0; rise_ok = 0; to = 1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge sys_clock);
            if (k == 1) fall_w1 = !phi2_fall_o;
            if (phi2_rise_o) begin
                rise_ok = cpu_clock_o;
                to = 0;
                break;
            end
            if (!cpu_clock_o) lo++;
        end
    endtask

    task automatic wait_rise(output bit to);
        to = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clock);
            if (phi2_rise_o) begin to = 0; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0;
        repeat (3) @(negedge sys_clock);
        checks++;
        if ({cpu_clock_o, phi2_rise_o, phi2_fall_o, data_setup_o, halted_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state: got clk/rise/fall/setup/halt=%b expected 00001",
                     {cpu_clock_o, phi2_rise_o, phi2_fall_o, data_setup_o, halted_o});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge sys_clock);
        checks++;
        if (halted_o !== 1'b1 || cpu_clock_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run: got halted=%b clk=%b expected 1 0", halted_o, cpu_clock_o);
        end
    endtask

    task automatic test_first_cycle();
        int exit_k, rise_k, hi, lo, gap, nsetup, nrise;
        bit fell_ok, fall_w1, rise_ok, to;
        exit_k = 0; rise_k = 0;
        speed = 2'd0; run = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge sys_clock);
            if (halted_o === 1'b0 && exit_k == 0) exit_k = k;
            if (phi2_rise_o === 1'b1) begin rise_k = k; break; end
        end
        // Inclusive count: the IDLE-exit tick is tick 1.
        checks++;
        if (rise_k == 0 || exit_k == 0 || rise_k - exit_k + 1 != 33) begin
            errors++;
            $display("FAIL first_rise: got exit=%0d rise=%0d span=%0d expected span 33",
                     exit_k, rise_k, rise_k - exit_k + 1);
        end
        checks++;
        if (cpu_clock_o !== 1'b1) begin
            errors++;
            $display("FAIL rise_coincident: got clk=%b expected 1", cpu_clock_o);
        end
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        checks++;
        if (to || hi != 32 || !fell_ok) begin
            errors++;
            $display("FAIL high_1x: got hi=%0d fell_ok=%0b to=%0b expected 32 1 0", hi, fell_ok, to);
        end
        checks++;
        if (gap != 2 || nsetup != 1 || nrise != 0) begin
            errors++;
            $display("FAIL strobes_1x: got gap=%0d nsetup=%0d nrise=%0d expected 2 1 0", gap, nsetup, nrise);
        end
        measure_low(lo, fall_w1, rise_ok, to);
        checks++;
        if (to || lo != 32 || !fall_w1 || !rise_ok) begin
            errors++;
            $display("FAIL low_1x: got lo=%0d fall_w1=%0b rise_ok=%0b to=%0b expected 32 1 1 0",
                     lo, fall_w1, rise_ok, to);
        end
        checks++;
        if (hi + lo != 64) begin
            errors++;
            $display("FAIL period_1x: got %0d expected 64", hi + lo);
        end
    endtask

    task automatic test_speed_change();
        int hi, lo, gap, nsetup, nrise;
        bit fell_ok, fall_w1, rise_ok, to;
        speed = 2'd3;
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        checks++;
        if (to || hi != 32 || gap != 2) begin
            errors++;
            $display("FAIL speed_current_high: got hi=%0d gap=%0d to=%0b expected 32 2 0", hi, gap, to);
        end
        measure_low(lo, fall_w1, rise_ok, to);
        checks++;
        if (to || lo != 4) begin
            errors++;
            $display("FAIL speed_next_low: got lo=%0d to=%0b expected 4 0", lo, to);
        end
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        checks++;
        if (to || hi != 4 || gap != 2 || nsetup != 1 || !fell_ok) begin
            errors++;
            $display("FAIL high_8x: got hi=%0d gap=%0d nsetup=%0d fell_ok=%0b expected 4 2 1 1",
                     hi, gap, nsetup, fell_ok);
        end
        measure_low(lo, fall_w1, rise_ok, to);
        checks++;
        if (to || lo != 4 || hi + lo != 8) begin
            errors++;
            $display("FAIL low_8x: got lo=%0d period=%0d expected 4 8", lo, hi + lo);
        end
    endtask

    task automatic test_run_halt();
        int hi, lo, gap, nsetup, nrise, bad;
        bit fell_ok, fall_w1, rise_ok, to;
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        run = 1'b0;
        @(negedge sys_clock);
        run = 1'b1;
        checks++;
        if (halted_o !== 1'b0) begin
            errors++;
            $display("FAIL run_glitch_phi1: got halted=%b expected 0", halted_o);
        end
        measure_low(lo, fall_w1, rise_ok, to);
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        checks++;
        if (to || halted_o !== 1'b0 || hi != 4) begin
            errors++;
            $display("FAIL run_glitch_no_halt: got halted=%b hi=%0d to=%0b expected 0 4 0", halted_o, hi, to);
        end
        measure_low(lo, fall_w1, rise_ok, to);
        run = 1'b0;
        measure_high(hi, gap, nsetup, nrise, fell_ok, to);
        checks++;
        if (to || hi != 4 || halted_o !== 1'b1 || !fell_ok) begin
            errors++;
            $display("FAIL halt_at_fall: got hi=%0d halted=%b fell_ok=%0b to=%0b expected 4 1 1 0",
                     hi, halted_o, fell_ok, to);
        end
        bad = 0;
        repeat (20) begin
            @(negedge sys_clock);
            if (cpu_clock_o !== 1'b0 || phi2_rise_o !== 1'b0 || halted_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halted_quiet: got %0d bad ticks expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bit to;
        speed = 2'd0; run = 1'b1;
        wait_rise(to);
        repeat (10) @(negedge sys_clock);
        checks++;
        if (to || cpu_clock_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high: got clk=%b to=%0b expected 1 0", cpu_clock_o, to);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (cpu_clock_o !== 1'b0 || halted_o !== 1'b1 || phi2_fall_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got clk=%b halted=%b fall=%b expected 0 1 0",
                     cpu_clock_o, halted_o, phi2_fall_o);
        end
        bad = 0;
        repeat (3) begin
            @(negedge sys_clock);
            if (phi2_fall_o !== 1'b0 || cpu_clock_o !== 1'b0) bad++;
        end
        run = 1'b0;
        reset_n = 1'b1;
        @(negedge sys_clock);
        checks++;
        if (bad != 0 || halted_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: got bad=%0d halted=%b expected 0 1", bad, halted_o);
        end
    endtask

`ifdef CPU_CLOCK_STRETCH_EN
    task automatic test_stretch();
        int hi, nsetup, fall_k;
        bit to;
        speed = 2'd0; run = 1'b1;
        wait_rise(to);
        hi = 1; nsetup = 0; fall_k = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge sys_clock);
            if (phi2_fall_o) begin fall_k = j; break; end
            if (cpu_clock_o) hi++;
            if (data_setup_o) nsetup++;
            stretch = (j >= 31 && j < 41);
        end
        stretch = 1'b0;
        checks++;
        if (to || hi != 42 || fall_k != 42) begin
            errors++;
            $display("FAIL stretch_high: got hi=%0d fall_at=%0d to=%0b expected 42 42 0", hi, fall_k, to);
        end
        checks++;
        if (nsetup != 1 || cpu_clock_o !== 1'b0) begin
            errors++;
            $display("FAIL stretch_setup: got nsetup=%0d clk=%b expected 1 0", nsetup, cpu_clock_o);
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_cycle();
        test_speed_change();
        test_run_halt();
        test_reset_mid();
`ifdef CPU_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
